uart_ext_responder: RTL and testbench
=====================================

// Module: uart_ext_responder
// PURPOSE
// Bus responder that terminates the CPU external-device request interface on the UART link.
// Writes to DATA_ADDR are serialised little-endian into 1/2/4 bytes, paced into the uart_transmitter.
// Reads from DATA_ADDR are served from an RX FIFO filled by the uart_receiver.
// Reads from STATUS_ADDR return link state. Sits in main_top between mips_cpu and the UART pair.
// PARAMETERS
// DATA_WIDTH     32      request data width (fixed 32; byte lanes 0..3)
// ADDR_WIDTH     16      request address width
// CLKS_PER_BYTE  104167  clocks between tx_start pulses (10 bits @ 9600 baud, 100 MHz); >=2
// FIFO_LOG2      4       RX FIFO depth = 2**FIFO_LOG2 bytes
// DATA_ADDR      16'h0   data register address;  STATUS_ADDR 16'h4 status register address
// PORTS
// clk         in   1           system clock, all logic on rising edge
// rst         in   1           asynchronous, active-high reset
// req_valid   in   1           request pending; initiator holds it and all req_* stable until resp_done
// req_rw      in   1           1 = write, 0 = read
// req_addr    in   ADDR_WIDTH  target register
// req_size    in   2           0 = byte, 1 = half, 2/3 = word
// req_wdata   in   DATA_WIDTH  write data, byte 0 = [7:0] sent first
// resp_done   out  1           one-cycle completion pulse
// resp_rdata  out  DATA_WIDTH  read data, valid in the resp_done cycle
// rx_data     in   8           byte from uart_receiver
// rx_valid    in   1           one-cycle strobe: rx_data valid
// tx_data     out  8           byte to uart_transmitter
// tx_start    out  1           one-cycle transmit strobe
// BEHAVIOUR
// Reset values: resp_done=0, resp_rdata=0, tx_start=0, tx_data=0, FIFO empty, overflow=0, state IDLE.
// nbytes = 1/2/4 for size 0/1/2-3; idx = current byte index.
// IDLE: when req_valid=1 the request is latched and state is chosen next cycle:
//  - addr==STATUS_ADDR, read  -> DONE; rdata = {16'b0, rx_count[7:0], 5'b0, overflow, rx_nonempty, tx_idle}.
//    overflow clears in the same cycle.
//  - addr==STATUS_ADDR, write -> DONE (ignored)
//  - addr==DATA_ADDR, write   -> TX_SEND, idx=0
//  - addr==DATA_ADDR, read    -> RX_WAIT, idx=0, rdata cleared
//  - any other addr -> DONE; read returns 0, write is ignored.
// TX_SEND (1 cycle): tx_start=1, tx_data=wdata[8*idx+:8].
//   Next state is TX_GAP with gap counter = CLKS_PER_BYTE-2.
// TX_GAP: decrement; at 0: idx==nbytes-1 -> DONE, else idx++ -> TX_SEND.
//   tx_start pulses are therefore exactly CLKS_PER_BYTE cycles apart.
// RX_WAIT: while rx_count < nbytes (evaluated at idx=0) stall; once satisfied, pop one byte per cycle.
//   Each popped byte goes into rdata[8*idx+:8]; after nbytes pops -> DONE. Upper bytes are zero for byte/half.
// DONE: resp_done=1 for exactly one cycle; rdata held until next request completes; -> IDLE.
//   IDLE ignores req_valid in the cycle immediately after DONE (initiator drops it).
// Latency: status/invalid = 2 cycles req->done; write = 1 + nbytes*CLKS_PER_BYTE + 1.
//   Read with data present = 2 + nbytes.
// tx_idle = (state not TX_SEND/TX_GAP); rx_nonempty = rx_count!=0.
// RX FIFO: circular, FIFO_LOG2-bit pointers wrap; rx_count is FIFO_LOG2+1 bits.
// Push on rx_valid in any state. Full and no pop: byte dropped, overflow sticky set.
// Pop and push in the same cycle when full: both occur, count unchanged, no overflow.
// Status read and overflow event in the same cycle: overflow ends set.
// rst mid-operation: immediate return to reset values; partially sent word abandoned; FIFO contents lost.
// No combinational path from req_* to resp_*/tx_*; all outputs registered.
// TESTING (CLKS_PER_BYTE=8, FIFO_LOG2=2)
// 1 write DATA, size 2, wdata 32'hA1B2C3D4 -> tx_start pulses with D4,C3,B2,A1 spaced 8 cycles; one resp_done.
// 2 rx bytes 11,22,33 then read DATA size 1 -> rdata 32'h00002211, done; status then shows count 1.
// 3 read DATA size 2 with FIFO empty -> stall, no done; feed 4 bytes 01..04 -> rdata 32'h04030201.
// 4 push 5 bytes into empty 4-deep FIFO -> 5th dropped; status bit2=1, count 4; 2nd status read bit2=0.
// 5 assert rst during 2nd byte of word write -> tx_start=0 next cycle; state IDLE, FIFO empty.
//   New status read -> 32'h00000001.
// 6 push with pop while full, plus read of unmapped addr 16'h8 -> count stays 4, no overflow; rdata 0.

Source files
------------

// File: rtl/uart_ext_responder.sv
// Bus responder bridging CPU external-device requests onto a UART byte link.
// Writes are serialised little-endian into paced tx_start strobes; reads drain an RX FIFO.
module uart_ext_responder #(
    parameter int unsigned DATA_WIDTH              = 32,
    parameter int unsigned ADDR_WIDTH              = 16,
    parameter int unsigned CLKS_PER_BYTE           = 104167,
    parameter int unsigned FIFO_LOG2               = 4,
    parameter logic [ADDR_WIDTH-1:0] DATA_ADDR     = '0,
    parameter logic [ADDR_WIDTH-1:0] STATUS_ADDR   = ADDR_WIDTH'(4)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    input  logic                  req_rw,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [1:0]            req_size,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_done,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic [7:0]            tx_data,
    output logic                  tx_start
);
    localparam int unsigned GapW  = (CLKS_PER_BYTE > 2) ? $clog2(CLKS_PER_BYTE) : 1;
    localparam int unsigned Depth = 2 ** FIFO_LOG2;
    localparam logic [FIFO_LOG2:0] FullCount = {1'b1, {FIFO_LOG2{1'b0}}};

    typedef enum logic [2:0] {StIdle, StDecode, StTxSend, StTxGap, StRxWait, StDone} state_e;

    state_e                  state_q, state_d;
    logic [1:0]              idx_q, idx_d, last_q, last_d;
    logic [GapW-1:0]         gap_q, gap_d;
    logic                    rw_q, rw_d, skip_q, skip_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d, rdata_q, rdata_d;
    logic [7:0]              tx_data_q, tx_data_d;
    logic                    tx_start_q, tx_start_d, resp_done_q, resp_done_d;

    logic [7:0]              fifo_mem [Depth];
    logic [FIFO_LOG2-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [FIFO_LOG2:0]      rx_count_q, rx_count_d;
    logic                    overflow_q, overflow_d;
    logic                    pop, push, full, status_rd;
    logic                    tx_idle;
    logic [31:0]             count_ext;
    logic [DATA_WIDTH-1:0]   status_word;

    assign full        = (rx_count_q == FullCount);
    assign push        = rx_valid && (!full || pop);
    assign tx_idle     = !((state_q == StTxSend) || (state_q == StTxGap));
    assign count_ext   = 32'(rx_count_q);
    assign status_word = DATA_WIDTH'({count_ext[7:0], 5'b0, overflow_q,
                                      (rx_count_q != '0), tx_idle});

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        last_d    = last_q;
        gap_d     = gap_q;
        rw_d      = rw_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        tx_data_d = tx_data_q;
        pop       = 1'b0;
        status_rd = 1'b0;
        // The initiator drops req_valid only after seeing resp_done, so skip one cycle.
        skip_d    = (state_q == StDone);
        unique case (state_q)
            StIdle: begin
                if (req_valid && !skip_q) begin
                    rw_d    = req_rw;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    last_d  = (req_size == 2'd0) ? 2'd0 : (req_size == 2'd1) ? 2'd1 : 2'd3;
                    state_d = StDecode;
                end
            end
            StDecode: begin
                idx_d = 2'd0;
                if (addr_q == STATUS_ADDR) begin
                    if (!rw_q) begin
                        rdata_d   = status_word;
                        status_rd = 1'b1;
                    end
                    state_d = StDone;
                end else if (addr_q == DATA_ADDR) begin
                    if (rw_q) begin
                        tx_data_d = wdata_q[7:0];
                        state_d   = StTxSend;
                    end else begin
                        rdata_d = '0;
                        state_d = StRxWait;
                    end
                end else begin
                    if (!rw_q) begin
                        rdata_d = '0;
                    end
                    state_d = StDone;
                end
            end
            StTxSend: begin
                gap_d   = GapW'(CLKS_PER_BYTE - 2);
                state_d = StTxGap;
            end
            StTxGap: begin
                if (gap_q == '0) begin
                    if (idx_q == last_q) begin
                        state_d = StDone;
                    end else begin
                        idx_d     = idx_q + 2'd1;
                        tx_data_d = wdata_q[{idx_d, 3'b000} +: 8];
                        state_d   = StTxSend;
                    end
                end else begin
                    gap_d = gap_q - GapW'(1);
                end
            end
            StRxWait: begin
                // Wait for the whole transfer up front, then drain one byte per cycle.
                if ((idx_q != 2'd0) || (count_ext > 32'(last_q))) begin
                    pop = 1'b1;
                    rdata_d[{idx_q, 3'b000} +: 8] = fifo_mem[rd_ptr_q];
                    if (idx_q == last_q) begin
                        state_d = StDone;
                    end else begin
                        idx_d = idx_q + 2'd1;
                    end
                end
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
        tx_start_d  = (state_d == StTxSend);
        resp_done_d = (state_d == StDone);
    end

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        rx_count_d = rx_count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + FIFO_LOG2'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + FIFO_LOG2'(1);
        end
        if (push && !pop) begin
            rx_count_d = rx_count_q + (FIFO_LOG2 + 1)'(1);
        end else if (pop && !push) begin
            rx_count_d = rx_count_q - (FIFO_LOG2 + 1)'(1);
        end
        overflow_d = (overflow_q && !status_rd) || (rx_valid && full && !pop);
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= rx_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            idx_q       <= '0;
            last_q      <= '0;
            gap_q       <= '0;
            rw_q        <= 1'b0;
            skip_q      <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            tx_data_q   <= '0;
            tx_start_q  <= 1'b0;
            resp_done_q <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            rx_count_q  <= '0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            last_q      <= last_d;
            gap_q       <= gap_d;
            rw_q        <= rw_d;
            skip_q      <= skip_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            tx_data_q   <= tx_data_d;
            tx_start_q  <= tx_start_d;
            resp_done_q <= resp_done_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            rx_count_q  <= rx_count_d;
            overflow_q  <= overflow_d;
        end
    end

    assign resp_done  = resp_done_q;
    assign resp_rdata = rdata_q;
    assign tx_data    = tx_data_q;
    assign tx_start   = tx_start_q;

endmodule

// File: tb/tb_uart_ext_responder.sv
// Directed bench for uart_ext_responder with an 8-clock byte period and a 4-deep RX FIFO.
module tb_uart_ext_responder;
    localparam int unsigned Cpb = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_rw = 1'b0;
    logic [15:0] req_addr = '0;
    logic [1:0]  req_size = '0;
    logic [31:0] req_wdata = '0;
    logic        resp_done;
    logic [31:0] resp_rdata;
    logic [7:0]  rx_data = '0;
    logic        rx_valid = 1'b0;
    logic [7:0]  tx_data;
    logic        tx_start;

    int          n_chk = 0;
    int          n_pass = 0;
    int          cyc = 0;
    logic [7:0]  txq [$];
    int          tq [$];

    always #5 clk = ~clk;

    uart_ext_responder #(
        .DATA_WIDTH   (32),
        .ADDR_WIDTH   (16),
        .CLKS_PER_BYTE(Cpb),
        .FIFO_LOG2    (2),
        .DATA_ADDR    (16'h0),
        .STATUS_ADDR  (16'h4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_rw    (req_rw),
        .req_addr  (req_addr),
        .req_size  (req_size),
        .req_wdata (req_wdata),
        .resp_done (resp_done),
        .resp_rdata(resp_rdata),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .tx_data   (tx_data),
        .tx_start  (tx_start)
    );

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        if (tx_start === 1'b1) begin
            txq.push_back(tx_data);
            tq.push_back(cyc);
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        step();
        rx_valid = 1'b0;
    endtask

    task automatic start_req(input logic rw, input logic [15:0] addr, input logic [1:0] size,
                             input logic [31:0] wdata);
        req_rw    = rw;
        req_addr  = addr;
        req_size  = size;
        req_wdata = wdata;
        req_valid = 1'b1;
    endtask

    // Drop the request after completion and let the responder settle back to accepting.
    task automatic end_req(input string tag);
        req_valid = 1'b0;
        step();
        check_eq({tag, "_pulse"}, 32'(resp_done), 32'd0);
        step();
    endtask

    task automatic txn(input string tag, input logic rw, input logic [15:0] addr,
                       input logic [1:0] size, input logic [31:0] wdata, input int max_cyc,
                       output logic [31:0] rdata, output int lat);
        bit ok;
        ok    = 1'b0;
        lat   = 0;
        rdata = '0;
        start_req(rw, addr, size, wdata);
        while (!ok && lat < max_cyc) begin
            step();
            lat++;
            if (resp_done === 1'b1) begin
                ok    = 1'b1;
                rdata = resp_rdata;
            end
        end
        check_eq({tag, "_done"}, 32'(ok), 32'd1);
        end_req(tag);
    endtask

    initial begin
        logic [31:0] rd;
        int          lat;
        int          seen;
        int          early;
        logic [7:0]  exp_b [4];
        logic [7:0]  got_b;

        // Reset values
        step();
        step();
        check_eq("rst_done", 32'(resp_done), 32'd0);
        check_eq("rst_rdata", resp_rdata, 32'd0);
        check_eq("rst_txstart", 32'(tx_start), 32'd0);
        check_eq("rst_txdata", 32'(tx_data), 32'd0);
        rst = 1'b0;
        step();

        // 1: word write, four paced bytes
        txq.delete();
        tq.delete();
        txn("wr_word", 1'b1, 16'h0, 2'd2, 32'hA1B2C3D4, 100, rd, lat);
        check_eq("wr_lat", 32'(lat), 32'(2 + 4 * Cpb));
        repeat (10) step();
        check_eq("wr_npulse", 32'(txq.size()), 32'd4);
        exp_b = '{8'hD4, 8'hC3, 8'hB2, 8'hA1};
        for (int i = 0; i < 4; i++) begin
            got_b = (i < txq.size()) ? txq[i] : 8'h00;
            check_eq($sformatf("wr_byte%0d", i), 32'(got_b), 32'(exp_b[i]));
        end
        for (int i = 1; i < 4; i++) begin
            check_eq($sformatf("wr_gap%0d", i),
                     (i < tq.size()) ? 32'(tq[i] - tq[i-1]) : 32'd0, 32'(Cpb));
        end

        // 2: half read with data present, then status shows one byte left
        push_byte(8'h11);
        step();
        push_byte(8'h22);
        push_byte(8'h33);
        txn("rd_half", 1'b0, 16'h0, 2'd1, 32'h0, 50, rd, lat);
        check_eq("rd_half_data", rd, 32'h00002211);
        check_eq("rd_half_lat", 32'(lat), 32'd4);
        txn("st1", 1'b0, 16'h4, 2'd2, 32'h0, 50, rd, lat);
        check_eq("st1_data", rd, 32'h00000103);
        check_eq("st1_lat", 32'(lat), 32'd2);
        txn("rd_byte", 1'b0, 16'h0, 2'd0, 32'h0, 50, rd, lat);
        check_eq("rd_byte_data", rd, 32'h00000033);
        check_eq("rd_byte_lat", 32'(lat), 32'd3);

        // 3: word read on an empty FIFO stalls until four bytes arrive
        start_req(1'b0, 16'h0, 2'd2, 32'h0);
        early = 0;
        repeat (20) begin
            step();
            if (resp_done === 1'b1) early++;
        end
        check_eq("stall_nodone", 32'(early), 32'd0);
        for (int i = 1; i <= 4; i++) begin
            push_byte(8'(i));
            if (resp_done === 1'b1) early++;
        end
        seen = 0;
        rd   = '0;
        for (int i = 0; i < 20 && seen == 0; i++) begin
            step();
            if (resp_done === 1'b1) begin
                seen = 1;
                rd   = resp_rdata;
            end
        end
        check_eq("stall_done", 32'(seen), 32'd1);
        check_eq("stall_data", rd, 32'h04030201);
        end_req("stall");

        // 4: overflow on fifth push, sticky until one status read
        for (int i = 0; i < 5; i++) push_byte(8'hA0 + 8'(i));
        txn("ovf_st1", 1'b0, 16'h4, 2'd2, 32'h0, 50, rd, lat);
        check_eq("ovf_st1_data", rd, 32'h00000407);
        txn("ovf_st2", 1'b0, 16'h4, 2'd2, 32'h0, 50, rd, lat);
        check_eq("ovf_st2_data", rd, 32'h00000403);
        txn("ovf_rd", 1'b0, 16'h0, 2'd2, 32'h0, 50, rd, lat);
        check_eq("ovf_rd_data", rd, 32'hA3A2A1A0);

        // 5: reset during second byte of a word write
        push_byte(8'h5A);
        start_req(1'b1, 16'h0, 2'd2, 32'h55667788);
        seen = 0;
        for (int i = 0; i < 40 && seen < 2; i++) begin
            step();
            if (tx_start === 1'b1) seen++;
        end
        check_eq("rst_mid_seen2", 32'(seen), 32'd2);
        check_eq("rst_mid_byte", 32'(tx_data), 32'h77);
        rst       = 1'b1;
        req_valid = 1'b0;
        step();
        check_eq("rst_mid_txstart", 32'(tx_start), 32'd0);
        check_eq("rst_mid_done", 32'(resp_done), 32'd0);
        rst = 1'b0;
        step();
        txn("rst_st", 1'b0, 16'h4, 2'd2, 32'h0, 50, rd, lat);
        check_eq("rst_st_data", rd, 32'h00000001);
        check_eq("rst_st_lat", 32'(lat), 32'd2);

        // 6: push and pop in the same cycle while full, then unmapped read
        for (int i = 0; i < 4; i++) push_byte(8'hB1 + 8'(i));
        start_req(1'b0, 16'h0, 2'd0, 32'h0);
        step();
        step();
        rx_data  = 8'hB5;
        rx_valid = 1'b1;
        step();
        rx_valid = 1'b0;
        check_eq("full_pp_done", 32'(resp_done), 32'd1);
        check_eq("full_pp_data", resp_rdata, 32'h000000B1);
        end_req("full_pp");
        txn("full_st", 1'b0, 16'h4, 2'd2, 32'h0, 50, rd, lat);
        check_eq("full_st_data", rd, 32'h00000403);
        txn("unmap", 1'b0, 16'h8, 2'd2, 32'h0, 50, rd, lat);
        check_eq("unmap_data", rd, 32'h00000000);
        check_eq("unmap_lat", 32'(lat), 32'd2);
        txn("full_rd", 1'b0, 16'h0, 2'd2, 32'h0, 50, rd, lat);
        check_eq("full_rd_data", rd, 32'hB5B4B3B2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
